// File: rtl/rv32_bus_pkg.sv
// rtl/rv32_bus_pkg.sv - shared owner encoding and bus widths for the rv32 bus arbiter
package rv32_bus_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;

  // IDLE doubles as "no effective owner" when it is the arbitration result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INSTR = 2'd1,
    DATA  = 2'd2
  } owner_t;
endpackage

// File: rtl/rv32_bus_timeout.sv
// rtl/rv32_bus_timeout.sv - wait-cycle counter that flags a stalled transfer as expired
module rv32_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic expired
);
  localparam bit ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_BITS-1:0] LAST =
    TIMEOUT_BITS'(ENABLED ? TIMEOUT_CYCLES - 1 : 0);

  logic [TIMEOUT_BITS-1:0] count_q;

  assign expired = ENABLED && active && !ready && (count_q == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (!ENABLED || !active || ready || expired) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + TIMEOUT_BITS'(1);
    end
  end
endmodule

// File: rtl/rv32_bus_arbiter.sv
// rtl/rv32_bus_arbiter.sv - shares one memory bus between fetch and mem-stage ports
// Optional round-robin under contention: RV32_BUS_ARBITER_FAIR_EN
module rv32_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] instr_address_in,
  input  logic              instr_read_in,
  output logic [DATA_W-1:0] instr_read_value_out,
  output logic              instr_ready_out,
  output logic              instr_fault_out,
  input  logic [ADDR_W-1:0] data_address_in,
  input  logic              data_read_in,
  input  logic              data_write_in,
  input  logic [MASK_W-1:0] data_write_mask_in,
  input  logic [DATA_W-1:0] data_write_value_in,
  output logic [DATA_W-1:0] data_read_value_out,
  output logic              data_ready_out,
  output logic              data_fault_out,
  output logic [ADDR_W-1:0] bus_address_out,
  output logic              bus_read_out,
  output logic              bus_write_out,
  output logic [MASK_W-1:0] bus_write_mask_out,
  output logic [DATA_W-1:0] bus_write_value_out,
  input  logic [DATA_W-1:0] bus_read_value_in,
  input  logic              bus_ready_in
);
  owner_t owner_q;
  owner_t eff;
  logic   data_req;
  logic   instr_first;
  logic   active;
  logic   expired;
  logic   complete;

  assign data_req = data_read_in | data_write_in;

`ifdef RV32_BUS_ARBITER_FAIR_EN
  logic fair_q;
  logic other_req;
  assign instr_first = fair_q;
  assign other_req   = (eff == INSTR) ? data_req :
                       (eff == DATA)  ? instr_read_in : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fair_q <= 1'b0;
    end else if (complete && other_req) begin
      fair_q <= ~fair_q;
    end
  end
`else
  assign instr_first = 1'b0;
`endif

  // A locked owner whose request disappears (pipeline flush) loses the bus at once
  always_comb begin
    eff = IDLE;
    if (!reset) begin
      case (owner_q)
        INSTR:   eff = instr_read_in ? INSTR : IDLE;
        DATA:    eff = data_req ? DATA : IDLE;
        default: begin
          if (instr_read_in && (instr_first || !data_req)) begin
            eff = INSTR;
          end else if (data_req) begin
            eff = DATA;
          end
        end
      endcase
    end
  end

  assign active   = (eff != IDLE);
  assign complete = active && (bus_ready_in || expired);

  rv32_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_BITS  (TIMEOUT_BITS)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .active (active),
    .ready  (bus_ready_in),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q <= IDLE;
    end else begin
      owner_q <= (active && !complete) ? eff : IDLE;
    end
  end

  assign bus_address_out     = (eff == DATA)  ? data_address_in :
                               (eff == INSTR) ? instr_address_in : '0;
  assign bus_read_out        = (eff == DATA) ? data_read_in : (eff == INSTR);
  assign bus_write_out       = (eff == DATA) && data_write_in;
  assign bus_write_mask_out  = (eff == DATA) ? data_write_mask_in : '0;
  assign bus_write_value_out = (eff == DATA) ? data_write_value_in : '0;

  assign instr_ready_out = (eff == INSTR) && (bus_ready_in || expired);
  assign instr_fault_out = (eff == INSTR) && expired;
  assign data_ready_out  = (eff == DATA) && (bus_ready_in || expired);
  assign data_fault_out  = (eff == DATA) && expired;

  assign instr_read_value_out = bus_read_value_in;
  assign data_read_value_out  = bus_read_value_in;
endmodule

// File: tb/tb_rv32_bus_arbiter.sv
// tb/tb_rv32_bus_arbiter.sv - vector-table bench for rv32_bus_arbiter (TIMEOUT_CYCLES=4)
module tb_rv32_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_address_in = '0;
  logic        instr_read_in = 1'b0;
  logic [31:0] instr_read_value_out;
  logic        instr_ready_out, instr_fault_out;
  logic [31:0] data_address_in = '0;
  logic        data_read_in = 1'b0, data_write_in = 1'b0;
  logic [3:0]  data_write_mask_in = '0;
  logic [31:0] data_write_value_in = '0;
  logic [31:0] data_read_value_out;
  logic        data_ready_out, data_fault_out;
  logic [31:0] bus_address_out;
  logic        bus_read_out, bus_write_out;
  logic [3:0]  bus_write_mask_out;
  logic [31:0] bus_write_value_out;
  logic [31:0] bus_read_value_in = '0;
  logic        bus_ready_in = 1'b0;

  always #5 clk = ~clk;

  rv32_bus_arbiter #(.TIMEOUT_CYCLES(4), .TIMEOUT_BITS(3)) dut (
    .clk(clk), .reset(reset),
    .instr_address_in(instr_address_in), .instr_read_in(instr_read_in),
    .instr_read_value_out(instr_read_value_out), .instr_ready_out(instr_ready_out),
    .instr_fault_out(instr_fault_out),
    .data_address_in(data_address_in), .data_read_in(data_read_in),
    .data_write_in(data_write_in), .data_write_mask_in(data_write_mask_in),
    .data_write_value_in(data_write_value_in), .data_read_value_out(data_read_value_out),
    .data_ready_out(data_ready_out), .data_fault_out(data_fault_out),
    .bus_address_out(bus_address_out), .bus_read_out(bus_read_out),
    .bus_write_out(bus_write_out), .bus_write_mask_out(bus_write_mask_out),
    .bus_write_value_out(bus_write_value_out), .bus_read_value_in(bus_read_value_in),
    .bus_ready_in(bus_ready_in)
  );

  // exp: {br, bw, addr, mask, wval, i_rdy, i_flt, d_rdy, d_flt, i_rval, d_rval}
  typedef struct {
    logic        rst, ir;
    logic [31:0] ia;
    logic        dr, dw;
    logic [3:0]  dm;
    logic [31:0] dv, da;
    logic        rdy;
    logic [31:0] rv;
    logic [137:0] exp;
  } vec_t;

  function automatic vec_t v(
    input logic rst, input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [3:0] dm,
    input logic [31:0] dv, input logic [31:0] da,
    input logic rdy, input logic [31:0] rv,
    input logic ebr, input logic ebw, input logic [31:0] eba,
    input logic [3:0] ebm, input logic [31:0] ebv,
    input logic eir, input logic eif, input logic edr, input logic edf);
    vec_t t;
    t.rst = rst; t.ir = ir; t.ia = ia; t.dr = dr; t.dw = dw; t.dm = dm;
    t.dv = dv; t.da = da; t.rdy = rdy; t.rv = rv;
    t.exp = {ebr, ebw, eba, ebm, ebv, eir, eif, edr, edf, rv, rv};
    return t;
  endfunction

  vec_t        vecs[$];
  logic [137:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  initial begin
    // reset holds everything low even with a request and ready present
    vecs.push_back(v(1,1,32'h100,0,0,0,0,0,1,0,               0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,0));
    // single-cycle fetch completes from IDLE
    vecs.push_back(v(0,1,32'h100,0,0,0,0,0,1,32'hDEADBEEF,    1,0,32'h100,0,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,0));
    // store with 3 wait cycles; ready lands on the timeout cycle and wins
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0,0,0,0,1,4'b0011,32'h1234,32'h2000,0,0, 0,1,32'h2000,4'b0011,32'h1234,0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,4'b0011,32'h1234,32'h2000,1,0,   0,1,32'h2000,4'b0011,32'h1234,0,0,1,0));
    // contention: data first, instr in the cycle after
    vecs.push_back(v(0,1,32'h300,1,0,0,0,32'h400,0,0,         1,0,32'h400,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'h300,1,0,0,0,32'h400,1,32'hAAAA0001, 1,0,32'h400,0,0,0,0,1,0));
    vecs.push_back(v(0,1,32'h300,0,0,0,0,0,0,0,               1,0,32'h300,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'h300,0,0,0,0,0,1,32'hBBBB0002,    1,0,32'h300,0,0,1,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,0));
    // instr arrives while data is locked
    vecs.push_back(v(0,0,0,1,0,0,0,32'h500,0,0,               1,0,32'h500,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'h600,1,0,0,0,32'h500,0,0,         1,0,32'h500,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'h600,1,0,0,0,32'h500,1,32'hCCCC0003, 1,0,32'h500,0,0,0,0,1,0));
    vecs.push_back(v(0,1,32'h600,0,0,0,0,0,1,0,               1,0,32'h600,0,0,1,0,0,0));
    // timeout on the 4th waiting cycle, then a fresh request is served
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0,0,0,1,0,0,0,32'h700,0,0,             1,0,32'h700,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0,0,32'h700,0,0,               1,0,32'h700,0,0,0,0,1,1));
    vecs.push_back(v(0,0,0,1,0,0,0,32'h704,1,0,               1,0,32'h704,0,0,0,0,1,0));
    // flushed fetch drops its strobe immediately
    vecs.push_back(v(0,1,32'h800,0,0,0,0,0,0,0,               1,0,32'h800,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,0,0,1,0,0,0,32'h900,1,0,               1,0,32'h900,0,0,0,0,1,0));
    // reset while instr is locked, then data is granted from IDLE
    vecs.push_back(v(0,1,32'hA00,0,0,0,0,0,0,0,               1,0,32'hA00,0,0,0,0,0,0));
    vecs.push_back(v(1,1,32'hA00,1,0,0,0,32'hB00,1,0,         0,0,0,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'hA00,1,0,0,0,32'hB00,0,0,         1,0,32'hB00,0,0,0,0,0,0));
    vecs.push_back(v(0,1,32'hA00,1,0,0,0,32'hB00,1,0,         1,0,32'hB00,0,0,0,0,1,0));
    // repeated conflict: fairness hands the next grant to instr
`ifdef RV32_BUS_ARBITER_FAIR_EN
    vecs.push_back(v(0,1,32'hC00,1,0,0,0,32'hD00,1,0,         1,0,32'hC00,0,0,1,0,0,0));
`else
    vecs.push_back(v(0,1,32'hC00,1,0,0,0,32'hD00,1,0,         1,0,32'hD00,0,0,0,0,1,0));
`endif
    vecs.push_back(v(0,0,0,0,0,0,0,0,0,0,                     0,0,0,0,0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      logic [137:0] got, want;
      @(posedge clk);
      #1;
      reset               = vecs[i].rst;
      instr_read_in       = vecs[i].ir;
      instr_address_in    = vecs[i].ia;
      data_read_in        = vecs[i].dr;
      data_write_in       = vecs[i].dw;
      data_write_mask_in  = vecs[i].dm;
      data_write_value_in = vecs[i].dv;
      data_address_in     = vecs[i].da;
      bus_ready_in        = vecs[i].rdy;
      bus_read_value_in   = vecs[i].rv;
      exp_q.push_back(vecs[i].exp);
      @(negedge clk);
      got = {bus_read_out, bus_write_out, bus_address_out, bus_write_mask_out,
             bus_write_value_out, instr_ready_out, instr_fault_out,
             data_ready_out, data_fault_out, instr_read_value_out, data_read_value_out};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL vec%0d scoreboard empty got=%h", i, got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL vec%0d got=%h exp=%h", i, got, want);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
